// File: rtl/sram_1rw1r_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_1rw1r_ctrl (with helper sram_1rw1r_ctrl_rsp_fifo)       |
// | Description : Initiator-side controller for a 1RW+1R OpenRAM macro.        |
// |               ch0 (read/write) drives macro port 0, ch1 (read-only) drives |
// |               macro port 1. Zero-fills the array after reset, then serves  |
// |               valid/ready requests with per-channel response FIFOs.        |
// |               Optional macro SRAM_CTRL_FWD_EN: forward full-mask ch0 write  |
// |               data to a same-address ch1 read instead of stalling ch1.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Response FIFO: read data waits here until the requester takes it
module sram_1rw1r_ctrl_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign pop_valid = (count != '0);
  assign pop       = pop_valid && pop_ready;
  assign pop_data  = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; reset flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  // ch0 request / response
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // ch1 request / response
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // macro port 0
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  // macro port 1
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int UW = CW + 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  run;

  // Read pipeline markers: p1 = pins driven, p2 = macro sampled, capture next edge
  logic rd0_p1, rd0_p2;
  logic rd1_p1, rd1_p2;

  logic [CW-1:0] fifo0_count, fifo1_count;
  logic [UW-1:0] used0, used1;
  logic          credit0, credit1;
  logic          collision, fwd_ok;
  logic          acc0, acc1, fwd1;
  logic [DATA_WIDTH-1:0] rsp1_push_data;

  assign run = (state == ST_RUN);

  // A read may only launch if its response is guaranteed a FIFO slot
  assign used0   = UW'(fifo0_count) + UW'(rd0_p1) + UW'(rd0_p2);
  assign used1   = UW'(fifo1_count) + UW'(rd1_p1) + UW'(rd1_p2);
  assign credit0 = (used0 < UW'(RSP_DEPTH));
  assign credit1 = (used1 < UW'(RSP_DEPTH));

  // Same-edge read and write of one address on the two ports gives undefined
  // read data from the macro, so the ch1 read must not launch alongside it
  assign collision = run && req0_valid && req0_we && (req0_addr == req1_addr);

  assign req0_ready = run && (req0_we || credit0);
  assign req1_ready = run && credit1 && (!collision || fwd_ok);

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign fwd1 = acc1 && fwd_ok;

`ifdef SRAM_CTRL_FWD_EN
  logic                  fwd_p1, fwd_p2;
  logic [DATA_WIDTH-1:0] fwd_data_p1, fwd_data_p2;

  // A full-mask write fully defines the word, so its data can answer the read
  assign fwd_ok = collision && (req0_wmask == '1);

  // Carry forwarded write data alongside the ch1 read pipeline to keep order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_p1      <= 1'b0;
      fwd_p2      <= 1'b0;
      fwd_data_p1 <= '0;
      fwd_data_p2 <= '0;
    end else begin
      fwd_p1 <= fwd1;
      fwd_p2 <= fwd_p1;
      if (fwd1) begin
        fwd_data_p1 <= req0_wdata;
      end
      fwd_data_p2 <= fwd_data_p1;
    end
  end

  assign rsp1_push_data = fwd_p2 ? fwd_data_p2 : dout1;
`else
  assign fwd_ok         = 1'b0;
  assign rsp1_push_data = dout1;
`endif

  // Control FSM plus port-0 pins: zero-fill sweep, then ch0 request issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_addr  <= '0;
      init_done <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
    end else begin
      // Idle unless a case below issues an access; addr/din hold
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      case (state)
        ST_INIT: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
        end
        ST_CLEAR: begin
          csb0     <= 1'b0;
          web0     <= 1'b0;
          wmask0   <= '1;
          addr0    <= clr_addr;
          din0     <= '0;
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == '1) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (acc0) begin
            csb0  <= 1'b0;
            web0  <= ~req0_we;
            addr0 <= req0_addr;
            if (req0_we) begin
              wmask0 <= req0_wmask;
              din0   <= req0_wdata;
            end
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Port-1 pins: a forwarded read never touches the macro
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb1  <= 1'b1;
      addr1 <= '0;
    end else begin
      csb1 <= ~(acc1 && !fwd1);
      if (acc1 && !fwd1) begin
        addr1 <= req1_addr;
      end
    end
  end

  // Read tracking: reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_p1 <= 1'b0;
      rd0_p2 <= 1'b0;
      rd1_p1 <= 1'b0;
      rd1_p2 <= 1'b0;
    end else begin
      rd0_p1 <= acc0 && !req0_we;
      rd0_p2 <= rd0_p1;
      rd1_p1 <= acc1;
      rd1_p2 <= rd1_p1;
    end
  end

  sram_1rw1r_ctrl_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp0_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd0_p2),
    .push_data (dout0),
    .pop_valid (rsp0_valid),
    .pop_ready (rsp0_ready),
    .pop_data  (rsp0_rdata),
    .count     (fifo0_count)
  );

  sram_1rw1r_ctrl_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp1_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd1_p2),
    .push_data (rsp1_push_data),
    .pop_valid (rsp1_valid),
    .pop_ready (rsp1_ready),
    .pop_data  (rsp1_rdata),
    .count     (fifo1_count)
  );
endmodule
`default_nettype wire
